// File: rtl/rect_ctl_pkg.sv
// Shared types and geometry helpers for the rectangle motion controller.
package rect_ctl_pkg;

  typedef enum logic [1:0] {
    ST_FOLLOW = 2'd0,
    ST_FALL   = 2'd1,
    ST_RISE   = 2'd2,
    ST_REST   = 2'd3
  } state_t;

  // Lowest legal top edge: the rectangle sits on the bottom of the screen.
  function automatic int unsigned floor_of(input int unsigned screen_h, input int unsigned rect_h);
    return screen_h - rect_h;
  endfunction

  function automatic int unsigned xmax_of(input int unsigned screen_w, input int unsigned rect_w);
    return screen_w - rect_w;
  endfunction

  function automatic int unsigned clamp(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle pulse every TICK_DIV clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 650000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
  end

endmodule

// File: rtl/rect_motion_ctl.sv
// Rectangle position controller: follows the mouse while held, falls (and optionally
// bounces) under constant acceleration once released.
module rect_motion_ctl
  import rect_ctl_pkg::*;
#(
  parameter int unsigned XY_W       = 12,
  parameter int unsigned VEL_W      = 8,
  parameter int unsigned SCREEN_W   = 800,
  parameter int unsigned SCREEN_H   = 600,
  parameter int unsigned RECT_W     = 48,
  parameter int unsigned RECT_H     = 64,
  parameter int unsigned TICK_DIV   = 650000,
  parameter int unsigned ACCEL      = 1,
  parameter int unsigned VMAX       = 60,
  parameter int unsigned BOUNCE_EN  = 0,
  parameter int unsigned DAMP_SHIFT = 1
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic [XY_W-1:0] mouse_xpos,
  input  logic [XY_W-1:0] mouse_ypos,
  input  logic            mouse_left,
  output logic [XY_W-1:0] xpos,
  output logic [XY_W-1:0] ypos,
  output logic            moving,
  output logic            at_rest
);

  localparam int unsigned FLOOR = floor_of(SCREEN_H, RECT_H);
  localparam int unsigned XMAX  = xmax_of(SCREEN_W, RECT_W);
  localparam logic [XY_W-1:0]  FLOOR_Y = XY_W'(FLOOR);
  localparam logic [XY_W:0]    FLOOR_E = (XY_W+1)'(FLOOR);
  localparam logic [VEL_W-1:0] ACCEL_V = VEL_W'(ACCEL);
  localparam logic [VEL_W-1:0] VMAX_V  = VEL_W'(VMAX);
  localparam logic [VEL_W:0]   VMAX_E  = (VEL_W+1)'(VMAX);
  localparam bit               BOUNCE  = (BOUNCE_EN != 0);

  state_t           state_q, state_d;
  logic [VEL_W-1:0] vel_q, vel_d;
  logic [XY_W-1:0]  xpos_d, ypos_d;
  logic             moving_d, at_rest_d;
  logic             btn_q;
  logic             tick_c;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (pclk),
    .rst_n  (rst),
    .tick_c (tick_c)
  );

  logic [XY_W-1:0]  cx_c, cy_c;
  logic [VEL_W:0]   vel_sum_c;
  logic [VEL_W-1:0] vel_fall_c, rebound_c, vel_rise_c;
  logic [XY_W:0]    y_sum_c;
  logic [XY_W-1:0]  y_fall_c, y_rise_c;
  logic             hit_c, bounce_c;

  assign cx_c = XY_W'(clamp(32'(mouse_xpos), XMAX));
  assign cy_c = XY_W'(clamp(32'(mouse_ypos), FLOOR));

  // Fall step: saturate velocity, then add in one extra bit so the floor clamp never wraps.
  assign vel_sum_c  = {1'b0, vel_q} + (VEL_W+1)'(ACCEL);
  assign vel_fall_c = (vel_sum_c > VMAX_E) ? VMAX_V : vel_sum_c[VEL_W-1:0];
  assign y_sum_c    = {1'b0, ypos} + (XY_W+1)'(vel_fall_c);
  assign y_fall_c   = (y_sum_c >= FLOOR_E) ? FLOOR_Y : y_sum_c[XY_W-1:0];
  assign hit_c      = (y_fall_c == FLOOR_Y);
  assign rebound_c  = vel_fall_c >> DAMP_SHIFT;
  assign bounce_c   = BOUNCE && (rebound_c != '0);

  assign y_rise_c   = ({1'b0, ypos} >= (XY_W+1)'(vel_q)) ? ypos - XY_W'(vel_q) : '0;
  assign vel_rise_c = (vel_q >= ACCEL_V) ? vel_q - ACCEL_V : '0;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state_q <= ST_FOLLOW;
    else      state_q <= state_d;
  end

  // A held button overrides everything, including a coincident tick.
  always_comb begin
    state_d = state_q;
    if (mouse_left) begin
      state_d = ST_FOLLOW;
    end else begin
      unique case (state_q)
        ST_FOLLOW: if (btn_q) state_d = ST_FALL;
        ST_FALL:   if (tick_c && hit_c) state_d = bounce_c ? ST_RISE : ST_REST;
        ST_RISE:   if (tick_c && (vel_rise_c == '0)) state_d = ST_FALL;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    xpos_d    = xpos;
    ypos_d    = ypos;
    vel_d     = vel_q;
    moving_d  = (state_d == ST_FALL) || (state_d == ST_RISE);
    at_rest_d = (state_d == ST_REST);
    if (mouse_left || (state_q == ST_FOLLOW)) begin
      xpos_d = cx_c;
      ypos_d = cy_c;
      vel_d  = '0;
    end else if (tick_c) begin
      if (state_q == ST_FALL) begin
        ypos_d = y_fall_c;
        vel_d  = hit_c ? (bounce_c ? rebound_c : '0) : vel_fall_c;
      end else if (state_q == ST_RISE) begin
        ypos_d = y_rise_c;
        vel_d  = vel_rise_c;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      xpos    <= '0;
      ypos    <= '0;
      vel_q   <= '0;
      moving  <= 1'b0;
      at_rest <= 1'b0;
      btn_q   <= 1'b0;
    end else begin
      xpos    <= xpos_d;
      ypos    <= ypos_d;
      vel_q   <= vel_d;
      moving  <= moving_d;
      at_rest <= at_rest_d;
      btn_q   <= mouse_left;
    end
  end

endmodule

// File: tb/tb_rect_motion_ctl.sv
// Bench for rect_motion_ctl: three configurations share one stimulus stream and are
// compared every cycle against a kinematic model, plus hand-computed checkpoints.
module tb_rect_motion_ctl;

  localparam int M_FOLLOW = 0;
  localparam int M_FALL   = 1;
  localparam int M_RISE   = 2;
  localparam int M_REST   = 3;
  localparam int FLOOR_PX = 536;
  localparam int XMAX_PX  = 752;

  typedef struct packed {
    int   mode;
    int   x;
    int   y;
    int   v;
    logic btn;
  } mdl_t;

  logic        clk;
  logic        rst_n;
  logic        ml;
  logic [11:0] mx, my;
  logic [11:0] xp [3];
  logic [11:0] yp [3];
  logic        mv [3];
  logic        ar [3];

  int   n_checks;
  int   n_pass;
  bit   chk_en;
  int   edge_n;
  bit   tick_seen;
  mdl_t m [3];

  int fall_a [4] = '{101, 103, 106, 110};
  int fall_c [4] = '{101, 103, 106, 109};
  int vsat_c [5] = '{1, 3, 6, 9, 12};

  rect_motion_ctl #(.XY_W(12), .VEL_W(8), .SCREEN_W(800), .SCREEN_H(600), .RECT_W(48),
    .RECT_H(64), .TICK_DIV(4), .ACCEL(1), .VMAX(60), .BOUNCE_EN(0), .DAMP_SHIFT(1)) u_dut_a (
    .pclk(clk), .rst(rst_n), .mouse_xpos(mx), .mouse_ypos(my), .mouse_left(ml),
    .xpos(xp[0]), .ypos(yp[0]), .moving(mv[0]), .at_rest(ar[0]));

  rect_motion_ctl #(.XY_W(12), .VEL_W(8), .SCREEN_W(800), .SCREEN_H(600), .RECT_W(48),
    .RECT_H(64), .TICK_DIV(4), .ACCEL(1), .VMAX(60), .BOUNCE_EN(1), .DAMP_SHIFT(1)) u_dut_b (
    .pclk(clk), .rst(rst_n), .mouse_xpos(mx), .mouse_ypos(my), .mouse_left(ml),
    .xpos(xp[1]), .ypos(yp[1]), .moving(mv[1]), .at_rest(ar[1]));

  rect_motion_ctl #(.XY_W(12), .VEL_W(8), .SCREEN_W(800), .SCREEN_H(600), .RECT_W(48),
    .RECT_H(64), .TICK_DIV(4), .ACCEL(1), .VMAX(3), .BOUNCE_EN(0), .DAMP_SHIFT(1)) u_dut_c (
    .pclk(clk), .rst(rst_n), .mouse_xpos(mx), .mouse_ypos(my), .mouse_left(ml),
    .xpos(xp[2]), .ypos(yp[2]), .moving(mv[2]), .at_rest(ar[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock of the physics: where the rectangle should be after this edge.
  function automatic mdl_t mdl_next(input mdl_t s, input int k, input bit tk, input bit btn,
                                    input int px, input int py);
    mdl_t n;
    int   vmax;
    int   nv;
    int   ny;
    n    = s;
    vmax = (k == 2) ? 3 : 60;
    if (btn || s.mode == M_FOLLOW) begin
      n.x = imin(px, XMAX_PX);
      n.y = imin(py, FLOOR_PX);
      n.v = 0;
      if (btn) n.mode = M_FOLLOW;
      else if (s.btn) n.mode = M_FALL;
    end else if (tk && s.mode == M_FALL) begin
      nv  = imin(s.v + 1, vmax);
      ny  = imin(s.y + nv, FLOOR_PX);
      n.y = ny;
      n.v = nv;
      if (ny == FLOOR_PX) begin
        if (k == 1 && (nv / 2) != 0) begin
          n.mode = M_RISE;
          n.v    = nv / 2;
        end else begin
          n.mode = M_REST;
          n.v    = 0;
        end
      end
    end else if (tk && s.mode == M_RISE) begin
      n.y = (s.y >= s.v) ? s.y - s.v : 0;
      n.v = (s.v >= 1) ? s.v - 1 : 0;
      if (n.v == 0) n.mode = M_FALL;
    end
    n.btn = btn;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n    <= 0;
      tick_seen <= 1'b0;
      for (int k = 0; k < 3; k++) m[k] <= '{mode: M_FOLLOW, x: 0, y: 0, v: 0, btn: 1'b0};
    end else begin
      edge_n    <= edge_n + 1;
      tick_seen <= (edge_n % 4 == 3);
      for (int k = 0; k < 3; k++)
        m[k] <= mdl_next(m[k], k, (edge_n % 4 == 3), ml, int'(mx), int'(my));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("dut%0d xpos", k), int'(xp[k]), m[k].x);
        check($sformatf("dut%0d ypos", k), int'(yp[k]), m[k].y);
        check($sformatf("dut%0d moving", k), int'(mv[k]),
              int'(m[k].mode == M_FALL || m[k].mode == M_RISE));
        check($sformatf("dut%0d at_rest", k), int'(ar[k]), int'(m[k].mode == M_REST));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic next_tick();
    int c;
    c = 0;
    do begin
      step(1);
      c++;
    end while (!tick_seen && c < 8);
  endtask

  task automatic wait_rest(input int k, input int budget);
    for (int c = 0; c < budget && !ar[k]; c++) step(1);
    check($sformatf("dut%0d reached rest", k), int'(ar[k]), 1);
  endtask

  task automatic press_release(input int px, input int py);
    ml = 1'b1; mx = 12'(px); my = 12'(py);
    step(1);
    ml = 1'b0;
    step(1);
  endtask

  initial begin
    int hit_a, hit_b, apex_a, apex_b, ymax_c;
    n_checks = 0; n_pass = 0; chk_en = 1'b0;
    rst_n = 1'b1; ml = 1'b0; mx = '0; my = '0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    check("reset xpos", int'(xp[0]), 0);
    check("reset ypos", int'(yp[0]), 0);
    check("reset moving", int'(mv[0]), 0);
    check("reset at_rest", int'(ar[0]), 0);
    #10 rst_n = 1'b1;
    step(1);

    // follow with clamping, then unclamped
    ml = 1'b1; mx = 12'd900; my = 12'd700;
    step(1);
    check("clamp xpos", int'(xp[0]), 752);
    check("clamp ypos", int'(yp[0]), 536);
    mx = 12'd100; my = 12'd100;
    step(1);
    check("follow xpos", int'(xp[0]), 100);
    check("follow ypos", int'(yp[0]), 100);

    // fall profile from y=100
    ml = 1'b0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      next_tick();
      check($sformatf("fall a tick%0d", i + 1), int'(yp[0]), fall_a[i]);
      check($sformatf("fall c tick%0d", i + 1), int'(yp[2]), fall_c[i]);
    end
    wait_rest(0, 400);
    check("fall a floor", int'(yp[0]), 536);
    check("fall a xpos kept", int'(xp[0]), 100);
    check("fall a not moving", int'(mv[0]), 0);

    // press coincident with a tick mid-fall
    press_release(100, 100);
    next_tick(); next_tick();
    check("pre-press ypos", int'(yp[0]), 103);
    step(3);
    ml = 1'b1; mx = 12'd200; my = 12'd50;
    step(1);
    check("press xpos", int'(xp[0]), 200);
    check("press ypos", int'(yp[0]), 50);
    check("press moving", int'(mv[0]), 0);
    check("press b ypos", int'(yp[1]), 50);
    ml = 1'b0;
    step(1);
    next_tick();
    check("refall tick1", int'(yp[0]), 51);
    next_tick();
    check("refall tick2", int'(yp[0]), 53);

    // bounce from y=500
    press_release(300, 500);
    hit_a = 0; hit_b = 0; apex_a = 1000; apex_b = 1000;
    for (int c = 0; c < 800 && !ar[1]; c++) begin
      step(1);
      if (hit_a != 0) apex_a = imin(apex_a, int'(yp[0]));
      if (hit_b != 0) apex_b = imin(apex_b, int'(yp[1]));
      if (yp[0] == 12'd536) hit_a = 1;
      if (yp[1] == 12'd536) hit_b = 1;
    end
    check("bounce b apex", apex_b, 526);
    check("bounce b reached rest", int'(ar[1]), 1);
    check("bounce b floor", int'(yp[1]), 536);
    check("no bounce a apex", apex_a, 536);

    // velocity saturation from y=0
    press_release(0, 0);
    for (int i = 0; i < 5; i++) begin
      next_tick();
      check($sformatf("vmax c tick%0d", i + 1), int'(yp[2]), vsat_c[i]);
    end
    ymax_c = 0;
    for (int c = 0; c < 1500 && !ar[2]; c++) begin
      step(1);
      if (int'(yp[2]) > ymax_c) ymax_c = int'(yp[2]);
    end
    check("vmax c reached rest", int'(ar[2]), 1);
    check("vmax c max ypos", ymax_c, 536);

    // asynchronous reset while falling
    press_release(100, 100);
    next_tick(); next_tick(); next_tick();
    check("mid-fall moving", int'(mv[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async reset xpos", int'(xp[0]), 0);
    check("async reset ypos", int'(yp[0]), 0);
    check("async reset moving", int'(mv[0]), 0);
    step(2);
    #1 rst_n = 1'b1;
    step(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
